store_queue_mc: RTL and testbench
=================================

// Module: store_queue_mc
// PURPOSE
//  Multi-channel successor of the SpMV store queue. Packs narrow SpMV result words into DDR-width beats,
//  one independent packer per output id. Each id has its own base address and beat counter. Partial beats
//  are flushed with a byte-enable on spmv_done. Single-clock block between the SpMV core and the DDR write
//  path (any clock crossing sits downstream).
// PARAMETERS
//  STQ_DATA_WIDTH   256  input word width; R = DDR_DATA_WIDTH/STQ_DATA_WIDTH lanes, power of 2, >=2
//  DDR_DATA_WIDTH   512  output beat width
//  ADDR_WIDTH       32   DDR byte address width
//  QPTR_WIDTH       5    output FIFO depth = 2^QPTR_WIDTH entries
//  IDS_NUM          4    number of channels (ids)
//  ID_WIDTH         8    req_id / ddr_id width
//  BASE_ADDR_WIDTH  20   per-id base, 4 KB granular
// PORTS
//  sys_clk    in   1                        clock
//  sys_rst    in   1                        reset, asynchronous, active-high
//  req_valid  in   1                        input word valid
//  req_ready  out  1                        input word accepted when valid&ready
//  req_id     in   ID_WIDTH                 target channel
//  req_data   in   STQ_DATA_WIDTH           result word
//  addr_base  in   BASE_ADDR_WIDTH*IDS_NUM  base of id k at bits [k*BASE_ADDR_WIDTH +: BASE_ADDR_WIDTH]; static during a run
//  spmv_done  in   1                        end-of-run pulse; starts flush
//  flush_done out  1                        1-cycle pulse: all data for the run written out
//  err_id     out  1                        sticky: a request arrived with req_id >= IDS_NUM
//  ddr_valid  out  1                        beat valid
//  ddr_ready  in   1                        beat taken when valid&ready
//  ddr_addr   out  ADDR_WIDTH               beat byte address
//  ddr_data   out  DDR_DATA_WIDTH           beat data; lane 0 in LSBs
//  ddr_be     out  DDR_DATA_WIDTH/8         byte enables
//  ddr_id     out  ID_WIDTH                 channel of beat
// BEHAVIOUR
//  Reset (async assert, sync release): ddr_valid=0, flush_done=0, err_id=0, FSM=IDLE, FIFO empty.
//   All lane counters, lane registers and beat counters are 0. req_ready=1 in the first cycle after release.
//  Per channel k: lane_cnt[k] (log2 R bits), pack register of R-1 lanes, beat_cnt[k] (27 bits).
//  Accept (req_valid & req_ready, id k < IDS_NUM):
//   - lane_cnt[k] < R-1: store word in lane lane_cnt[k]; lane_cnt[k]++.
//   - lane_cnt[k] = R-1: push a full beat into the FIFO in the same cycle, with no bubble.
//     data = {req_data, lanes R-2..0}, be = all ones. lane_cnt[k] <= 0; beat_cnt[k]++.
//  req_id >= IDS_NUM: word accepted and discarded, err_id <= 1 (cleared only by reset).
//  Push address = {base[k], 12'h0} + beat_cnt[k]*(DDR_DATA_WIDTH/8), taken modulo 2^ADDR_WIDTH.
//   Computed at push time and stored in the FIFO entry with data, be and id.
//  req_ready = (FSM==IDLE) & ~fifo_full. At most one push per cycle.
//  Output: first-word-fall-through FIFO. ddr_valid = ~empty. Pop on ddr_valid & ddr_ready.
//   All ddr_* outputs are held stable while ddr_valid & ~ddr_ready. Beat order = push order.
//   Latency: a full beat is visible on ddr_* the cycle after the completing accept.
//  FSM:
//   - IDLE -> FLUSH on spmv_done. An accept in the same cycle is taken and included in the flush.
//   - FLUSH scans ch = 0..IDS_NUM-1, one channel per cycle.
//     lane_cnt[ch] != 0: waits for ~fifo_full, then pushes a partial beat.
//       Filled lanes carry data; unfilled lanes carry 0. be = ones on filled lanes only.
//       lane_cnt[ch] <= 0; beat_cnt[ch]++.
//     lane_cnt[ch] = 0: no push, advance to the next channel.
//   - After channel IDS_NUM-1 -> DRAIN.
//   - DRAIN -> DONE when the FIFO is empty (last beat popped).
//   - DONE: flush_done=1 for 1 cycle, all beat_cnt <= 0, -> IDLE.
//   - spmv_done outside IDLE is ignored.
//  Reset mid-operation: all pending lanes and FIFO contents are discarded immediately.
//   ddr_valid drops in the same cycle as reset assertion.
// TESTING
//  1 STQ=256, DDR=512, base0=0x00001. Send id0 A then B -> one beat: addr 0x00001000, data {B,A}, be all ones.
//    A third and fourth word -> next beat at addr 0x00001040.
//  2 Interleave id0 A0, id1 B0, id0 A1, id1 B1 (base1=0x00002) -> beat {A1,A0} @0x1000 id0,
//    then {B1,B0} @0x2000 id1. No lane mixing between channels.
//  3 ddr_ready=0; send 2*2^QPTR_WIDTH words -> req_ready=0 once 32 beats are queued.
//    Release ddr_ready -> all 32 beats drain in order with no loss; ddr_* stable while stalled.
//  4 id1 holds 1 lane C; pulse spmv_done -> beat {0,C}, be = 64'h0000_0000_FFFF_FFFF, id1.
//    flush_done pulses after the pop; the next id1 beat restarts at addr base1<<12.
//  5 spmv_done in the same cycle as id0's second word -> full beat emitted, no partial.
//    spmv_done with nothing pending -> flush_done within IDLE+IDS_NUM+2 cycles and no ddr beat.
//  6 req_id=9 -> err_id=1, no beat produced. Assert sys_rst while ddr_valid=1 -> ddr_valid=0 immediately;
//    after release the FIFO is empty and req_ready=1.

Source files
------------

// File: rtl/store_queue_mc.sv
// Multi-channel store queue: packs narrow SpMV words into DDR-width beats, one packer per id,
// behind a shared first-word-fall-through beat FIFO. Partial beats are flushed on spmv_done.

module stq_chan #(
  parameter int STQ_DATA_WIDTH  = 256,
  parameter int R               = 2,
  parameter int LW              = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int BASE_ADDR_WIDTH = 20,
  parameter int DDR_BYTES       = 64,
  parameter int BCNT_W          = 27
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst,
  input  logic                                wr_en_i,
  input  logic                                flush_en_i,
  input  logic                                clr_beats_i,
  input  logic [STQ_DATA_WIDTH-1:0]           data_i,
  input  logic [BASE_ADDR_WIDTH-1:0]          base_i,
  output logic [LW-1:0]                       cnt_o,
  output logic [R-2:0][STQ_DATA_WIDTH-1:0]    lanes_o,
  output logic [R*STQ_DATA_WIDTH/8-1:0]       be_o,
  output logic [ADDR_WIDTH-1:0]               addr_o
);
  localparam int LB  = STQ_DATA_WIDTH / 8;
  localparam int BSH = $clog2(DDR_BYTES);

  logic [R-2:0][STQ_DATA_WIDTH-1:0] lanes_q;
  logic [LW-1:0]                    cnt_q;
  logic [BCNT_W-1:0]                beat_q;
  logic                             last_lane;

  assign last_lane = (cnt_q == LW'(R - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lanes_q <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else if (wr_en_i) begin
      if (last_lane) begin
        cnt_q  <= '0;
        beat_q <= beat_q + BCNT_W'(1);
      end else begin
        for (int i = 0; i < R - 1; i++)
          if (cnt_q == LW'(i)) lanes_q[i] <= data_i;
        cnt_q <= cnt_q + LW'(1);
      end
    end else if (flush_en_i) begin
      cnt_q  <= '0;
      beat_q <= beat_q + BCNT_W'(1);
    end else if (clr_beats_i) begin
      beat_q <= '0;
    end
  end

  // Lanes at or above the fill count hold stale words from earlier beats; mask them out.
  always_comb begin
    lanes_o = '0;
    be_o    = '0;
    for (int i = 0; i < R - 1; i++)
      if (LW'(i) < cnt_q) lanes_o[i] = lanes_q[i];
    for (int i = 0; i < R; i++)
      if (LW'(i) < cnt_q) be_o[i*LB +: LB] = '1;
  end

  assign cnt_o  = cnt_q;
  assign addr_o = ADDR_WIDTH'({base_i, 12'h000}) + (ADDR_WIDTH'(beat_q) << BSH);
endmodule

module store_queue_mc #(
  parameter int STQ_DATA_WIDTH  = 256,
  parameter int DDR_DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH      = 32,
  parameter int QPTR_WIDTH      = 5,
  parameter int IDS_NUM         = 4,
  parameter int ID_WIDTH        = 8,
  parameter int BASE_ADDR_WIDTH = 20
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [ID_WIDTH-1:0]                req_id,
  input  logic [STQ_DATA_WIDTH-1:0]          req_data,
  input  logic [BASE_ADDR_WIDTH*IDS_NUM-1:0] addr_base,
  input  logic                               spmv_done,
  output logic                               flush_done,
  output logic                               err_id,
  output logic                               ddr_valid,
  input  logic                               ddr_ready,
  output logic [ADDR_WIDTH-1:0]              ddr_addr,
  output logic [DDR_DATA_WIDTH-1:0]          ddr_data,
  output logic [DDR_DATA_WIDTH/8-1:0]        ddr_be,
  output logic [ID_WIDTH-1:0]                ddr_id
);
  localparam int R     = DDR_DATA_WIDTH / STQ_DATA_WIDTH;
  localparam int LW    = $clog2(R);
  localparam int BE_W  = DDR_DATA_WIDTH / 8;
  localparam int CW    = (IDS_NUM > 1) ? $clog2(IDS_NUM) : 1;
  localparam int DEPTH = 1 << QPTR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DDR_DATA_WIDTH-1:0] data;
    logic [BE_W-1:0]           be;
    logic [ID_WIDTH-1:0]       id;
  } beat_t;

  state_e                                         state_q, state_d;
  logic [CW-1:0]                                  scan_q, scan_d;
  logic                                           err_q;
  logic                                           clr_beats;

  logic [IDS_NUM-1:0]                             wr_en, flush_en;
  logic [IDS_NUM-1:0][LW-1:0]                     cnt;
  logic [IDS_NUM-1:0][R-2:0][STQ_DATA_WIDTH-1:0]  lanes;
  logic [IDS_NUM-1:0][BE_W-1:0]                   pbe;
  logic [IDS_NUM-1:0][ADDR_WIDTH-1:0]             paddr;

  logic                                           acc, id_ok, push_full, push_part, push, pop;
  logic [CW-1:0]                                  acc_ch, src;
  logic [STQ_DATA_WIDTH-1:0]                      top_lane;
  beat_t                                          push_beat, rd_beat;

  beat_t                                          mem_q [DEPTH];
  logic [QPTR_WIDTH:0]                            wptr_q, rptr_q;
  logic                                           fifo_empty, fifo_full;

  genvar k;
  generate
    for (k = 0; k < IDS_NUM; k++) begin : g_chan
      assign wr_en[k]    = acc & id_ok & (acc_ch == CW'(k));
      assign flush_en[k] = push_part & (scan_q == CW'(k));
      stq_chan #(
        .STQ_DATA_WIDTH (STQ_DATA_WIDTH),
        .R              (R),
        .LW             (LW),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .BASE_ADDR_WIDTH(BASE_ADDR_WIDTH),
        .DDR_BYTES      (BE_W),
        .BCNT_W         (27)
      ) u_chan (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wr_en_i    (wr_en[k]),
        .flush_en_i (flush_en[k]),
        .clr_beats_i(clr_beats),
        .data_i     (req_data),
        .base_i     (addr_base[k*BASE_ADDR_WIDTH +: BASE_ADDR_WIDTH]),
        .cnt_o      (cnt[k]),
        .lanes_o    (lanes[k]),
        .be_o       (pbe[k]),
        .addr_o     (paddr[k])
      );
    end
  endgenerate

  assign req_ready = (state_q == S_IDLE) & ~fifo_full;
  assign acc       = req_valid & req_ready;
  assign id_ok     = (req_id < ID_WIDTH'(IDS_NUM));
  assign acc_ch    = req_id[CW-1:0];

  // Accepts only happen in IDLE and flush pushes only in FLUSH, so the two never collide.
  assign push_full = acc & id_ok & (cnt[acc_ch] == LW'(R - 1));
  assign push_part = (state_q == S_FLUSH) & (cnt[scan_q] != '0) & ~fifo_full;
  assign push      = push_full | push_part;
  assign src       = push_full ? acc_ch : scan_q;
  assign top_lane  = push_full ? req_data : '0;

  always_comb begin
    push_beat.addr = paddr[src];
    push_beat.data = {top_lane, lanes[src]};
    push_beat.be   = push_full ? {BE_W{1'b1}} : pbe[src];
    push_beat.id   = push_full ? req_id : ID_WIDTH'(scan_q);
  end

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[QPTR_WIDTH] != rptr_q[QPTR_WIDTH]) &&
                      (wptr_q[QPTR_WIDTH-1:0] == rptr_q[QPTR_WIDTH-1:0]);
  assign pop        = ~fifo_empty & ddr_ready;

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wptr_q[QPTR_WIDTH-1:0]] <= push_beat;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (QPTR_WIDTH+1)'(1);
      if (pop)  rptr_q <= rptr_q + (QPTR_WIDTH+1)'(1);
    end
  end

  assign rd_beat   = mem_q[rptr_q[QPTR_WIDTH-1:0]];
  assign ddr_valid = ~fifo_empty;
  assign ddr_addr  = rd_beat.addr;
  assign ddr_data  = rd_beat.data;
  assign ddr_be    = rd_beat.be;
  assign ddr_id    = rd_beat.id;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      scan_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      if (acc & ~id_ok) err_q <= 1'b1;
    end
  end

  assign err_id = err_q;

  always_comb begin
    state_d    = state_q;
    scan_d     = scan_q;
    flush_done = 1'b0;
    clr_beats  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (spmv_done) begin
          state_d = S_FLUSH;
          scan_d  = '0;
        end
      end
      S_FLUSH: begin
        // A channel with pending lanes holds the scan until its partial beat fits.
        if ((cnt[scan_q] == '0) || !fifo_full) begin
          if (scan_q == CW'(IDS_NUM - 1)) state_d = S_DRAIN;
          else                            scan_d  = scan_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (fifo_empty) state_d = S_DONE;
      end
      S_DONE: begin
        flush_done = 1'b1;
        clr_beats  = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_store_queue_mc.sv
// Directed bench for store_queue_mc: packing, channel isolation, backpressure, flush and reset.
module tb_store_queue_mc;
  localparam int STQ = 256, DDR = 512, AW = 32, QW = 5, NID = 4, IW = 8, BW = 20, BEW = DDR / 8;

  logic              sys_clk = 1'b0, sys_rst = 1'b1;
  logic              req_valid = 1'b0, req_ready;
  logic [IW-1:0]     req_id = '0;
  logic [STQ-1:0]    req_data = '0;
  logic [BW*NID-1:0] addr_base = {20'h00004, 20'h00003, 20'h00002, 20'h00001};
  logic              spmv_done = 1'b0, flush_done, err_id;
  logic              ddr_valid, ddr_ready = 1'b0;
  logic [AW-1:0]     ddr_addr;
  logic [DDR-1:0]    ddr_data;
  logic [BEW-1:0]    ddr_be;
  logic [IW-1:0]     ddr_id;

  int checks = 0, errors = 0;
  localparam logic [63:0] BE_FULL = {64{1'b1}};
  localparam logic [63:0] BE_LO   = 64'h0000_0000_FFFF_FFFF;

  store_queue_mc #(
    .STQ_DATA_WIDTH(STQ), .DDR_DATA_WIDTH(DDR), .ADDR_WIDTH(AW), .QPTR_WIDTH(QW),
    .IDS_NUM(NID), .ID_WIDTH(IW), .BASE_ADDR_WIDTH(BW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_data(req_data), .addr_base(addr_base), .spmv_done(spmv_done),
    .flush_done(flush_done), .err_id(err_id), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
    .ddr_addr(ddr_addr), .ddr_data(ddr_data), .ddr_be(ddr_be), .ddr_id(ddr_id)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [STQ-1:0] w(input int unsigned n);
    return {8{n}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int id, input logic [STQ-1:0] d);
    int n = 0;
    req_valid = 1'b1; req_id = IW'(id); req_data = d;
    while (!req_ready && n < 200) begin @(negedge sys_clk); n++; end
    chk("send_ready", req_ready, 1);
    @(negedge sys_clk);
    req_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [AW-1:0] a, input logic [DDR-1:0] d,
                             input logic [63:0] be, input int id);
    int n = 0;
    while (!ddr_valid && n < 200) begin @(negedge sys_clk); n++; end
    chk({tag, "_vld"}, ddr_valid, 1);
    chk({tag, "_addr"}, ddr_addr, a);
    chk({tag, "_data"}, ddr_data, d);
    chk({tag, "_be"}, ddr_be, be);
    chk({tag, "_id"}, ddr_id, id);
    ddr_ready = 1'b1;
    @(negedge sys_clk);
    ddr_ready = 1'b0;
  endtask

  task automatic wait_flush(input string tag, output int cyc, output bit saw_vld);
    cyc = 0; saw_vld = 0;
    while (!flush_done && cyc < 20) begin
      if (ddr_valid) saw_vld = 1;
      @(negedge sys_clk); cyc++;
    end
    chk({tag, "_flush_done"}, flush_done, 1);
    @(negedge sys_clk);
    chk({tag, "_flush_pulse"}, flush_done, 0);
  endtask

  initial begin
    int  cyc;
    bit  saw;
    repeat (2) @(negedge sys_clk);
    chk("rst_ddr_valid", ddr_valid, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_err_id", err_id, 0);
    sys_rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);

    // 1: two words make one beat; the next beat is 64 bytes further on
    send(0, w(1));
    chk("t1_vld_nonempty_before", ddr_valid, 0);
    send(0, w(2));
    chk("t1_latency", ddr_valid, 1);
    expect_beat("t1_b0", 32'h0000_1000, {w(2), w(1)}, BE_FULL, 0);
    send(0, w(3)); send(0, w(4));
    expect_beat("t1_b1", 32'h0000_1040, {w(4), w(3)}, BE_FULL, 0);

    // 5b: flush with nothing pending emits no beat and clears beat counters
    spmv_done = 1'b1; @(negedge sys_clk); spmv_done = 1'b0;
    chk("t5b_busy_ready", req_ready, 0);
    wait_flush("t5b", cyc, saw);
    chk("t5b_latency", cyc <= NID + 2, 1);
    chk("t5b_no_beat", saw, 0);
    chk("t5b_vld_after", ddr_valid, 0);

    // 2: interleaved channels keep their lanes apart
    send(0, w(11)); send(1, w(21)); send(0, w(12)); send(1, w(22));
    expect_beat("t2_ch0", 32'h0000_1000, {w(12), w(11)}, BE_FULL, 0);
    expect_beat("t2_ch1", 32'h0000_2000, {w(22), w(21)}, BE_FULL, 1);

    // 3: fill FIFO under backpressure, then drain in order
    for (int i = 0; i < 64; i++) send(2, w(100 + i));
    chk("t3_full_ready", req_ready, 0);
    chk("t3_stall_vld", ddr_valid, 1);
    chk("t3_stall_addr0", ddr_addr, 32'h0000_3000);
    repeat (3) @(negedge sys_clk);
    chk("t3_stall_addr1", ddr_addr, 32'h0000_3000);
    chk("t3_stall_data1", ddr_data, {w(101), w(100)});
    chk("t3_stall_id1", ddr_id, 2);
    for (int b = 0; b < 32; b++)
      expect_beat($sformatf("t3_b%0d", b), 32'h0000_3000 + 32'(b * 64),
                  {w(100 + 2*b + 1), w(100 + 2*b)}, BE_FULL, 2);
    chk("t3_empty", ddr_valid, 0);
    chk("t3_ready_back", req_ready, 1);

    // 4: one pending lane on id1 is flushed as a half beat
    send(1, w(31));
    spmv_done = 1'b1; @(negedge sys_clk); spmv_done = 1'b0;
    expect_beat("t4_part", 32'h0000_2040, {256'h0, w(31)}, BE_LO, 1);
    chk("t4_done_after_pop", flush_done, 0);
    wait_flush("t4", cyc, saw);
    chk("t4_no_extra", saw, 0);
    send(1, w(41)); send(1, w(42));
    expect_beat("t4_restart", 32'h0000_2000, {w(42), w(41)}, BE_FULL, 1);

    // 5a: spmv_done together with the completing word: full beat, no partial
    send(0, w(51));
    spmv_done = 1'b1;
    send(0, w(52));
    spmv_done = 1'b0;
    expect_beat("t5a_full", 32'h0000_1000, {w(52), w(51)}, BE_FULL, 0);
    wait_flush("t5a", cyc, saw);
    chk("t5a_no_partial", saw, 0);
    chk("t5a_vld_after", ddr_valid, 0);
    chk("t5a_err_clear", err_id, 0);

    // 6: bad id is dropped and flagged; reset discards lanes and FIFO
    send(9, w(61));
    chk("t6_err_id", err_id, 1);
    chk("t6_no_beat", ddr_valid, 0);
    send(0, w(90));
    send(3, w(70)); send(3, w(71));
    chk("t6_vld_pre_rst", ddr_valid, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("t6_vld_async", ddr_valid, 0);
    chk("t6_err_rst", err_id, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("t6_ready_rel", req_ready, 1);
    chk("t6_vld_rel", ddr_valid, 0);
    send(0, w(91)); send(0, w(92));
    expect_beat("t6_clean", 32'h0000_1000, {w(92), w(91)}, BE_FULL, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
